seq_mag_comparator: RTL and testbench



---
 rtl/seq_mag_comparator.sv | 142 ++++++++++++++
 tb/tb_seq_mag_comparator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator with registered, held result flags.
// Latency: WIDTH edges from the accepting edge, or p+1 edges with SEQ_MAG_COMPARATOR_EARLY_EXIT_EN.
// Backpressure: START is taken only when not BUSY; a START during BUSY is dropped, never queued.
module seq_mag_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             AGTB,
    output logic             ALTB,
    output logic             AEQB
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx_q;
    logic             busy_q;
    logic             done_q;
    logic             agtb_q;
    logic             altb_q;
    logic             aeqb_q;

    logic a_bit;
    logic b_bit;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
    // First differing bit is sticky; later bit slices cannot overturn it.
    logic diff_q;
    logic gt_q;
    logic diff_d;
    logic gt_d;

    assign diff_d = diff_q | (a_bit ^ b_bit);
    assign gt_d   = diff_q ? gt_q : a_bit;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            agtb_q  <= 1'b0;
            altb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
            diff_q  <= 1'b0;
            gt_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        idx_q   <= IDX_MSB;
                        agtb_q  <= 1'b0;
                        altb_q  <= 1'b0;
                        aeqb_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
`ifndef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
                        diff_q  <= 1'b0;
                        gt_q    <= 1'b0;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_SCAN: begin
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
                    if (a_bit && !b_bit) begin
                        agtb_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (!a_bit && b_bit) begin
                        altb_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (idx_q == '0) begin
                        aeqb_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
`else
                    diff_q <= diff_d;
                    gt_q   <= gt_d;
                    if (idx_q == '0) begin
                        agtb_q  <= diff_d & gt_d;
                        altb_q  <= diff_d & ~gt_d;
                        aeqb_q  <= ~diff_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
`endif
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign AGTB = agtb_q;
    assign ALTB = altb_q;
    assign AEQB = aeqb_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator: vector table, corner sequences and random operands.
module tb_seq_mag_comparator;

    localparam int W = 4;

    logic         CLK;
    logic         RSTN;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic         AGTB;
    logic         ALTB;
    logic         AEQB;

    int n_total;
    int n_pass;

    seq_mag_comparator #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .START(START),
        .A    (A),
        .B    (B),
        .BUSY (BUSY),
        .DONE (DONE),
        .AGTB (AGTB),
        .ALTB (ALTB),
        .AEQB (AEQB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         gt;
        logic         lt;
        logic         eq;
        int           lat_ee;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: flags from plain unsigned compare; latency from the highest differing bit.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic gt, output logic lt, output logic eq, output int lat);
        int x;
        int h;
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
        x  = int'(a ^ b);
        h  = -1;
        for (int k = 0; k < W; k++)
            if ((x >> k) & 1) h = k;
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
        lat = (h < 0) ? W : (W - h);
`else
        lat = W;
`endif
    endtask

    function automatic int build_lat(input int lat_ee);
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
        return lat_ee;
`else
        return W;
`endif
    endfunction

    // Runs one comparison from the accepting edge through the DONE cycle.
    // started: START/A/B already driven by a previous chained call.
    // chain: hold START high with na/nb during the DONE cycle.
    // repulse: drive START with other operands during the first busy cycle.
    task automatic do_cmp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic egt, input logic elt, input logic eeq, input int elat,
                          input bit started, input bit chain,
                          input logic [W-1:0] na, input logic [W-1:0] nb, input bit repulse);
        int  lat;
        bit  seen;
        if (!started) begin
            START = 1'b1;
            A     = a;
            B     = b;
        end
        @(posedge CLK); #1;
        START = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        chk({tag, " busy_after_accept"}, 32'(BUSY), 32'd1);
        chk({tag, " flags_cleared"}, 32'({AGTB, ALTB, AEQB}), 32'd0);
        if (repulse) begin
            START = 1'b1;
            A     = ~a;
            B     = ~b;
        end
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= W + 4 && !seen; k++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            if (DONE) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                chk({tag, " busy_flags_in_scan"}, 32'({BUSY, AGTB, ALTB, AEQB}), 32'b1000);
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " flags"}, 32'({AGTB, ALTB, AEQB}), 32'({egt, elt, eeq}));
        chk({tag, " busy_in_done"}, 32'(BUSY), 32'd0);
        if (chain) begin
            START = 1'b1;
            A     = na;
            B     = nb;
        end else begin
            @(posedge CLK); #1;
            chk({tag, " done_pulse_end"}, 32'({DONE, BUSY}), 32'd0);
            chk({tag, " flags_held"}, 32'({AGTB, ALTB, AEQB}), 32'({egt, elt, eeq}));
        end
    endtask

    vec_t vecs[9];

    initial begin
        logic         gt;
        logic         lt;
        logic         eq;
        int           lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{4'b1010, 4'b0110, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{4'b0101, 4'b0111, 1'b0, 1'b1, 1'b0, 3};
        vecs[2] = '{4'b1001, 4'b1001, 1'b0, 1'b0, 1'b1, 4};
        vecs[3] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4};
        vecs[4] = '{4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0, 4};
        vecs[5] = '{4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 4};
        vecs[6] = '{4'b0011, 4'b1000, 1'b0, 1'b1, 1'b0, 1};
        vecs[7] = '{4'b0110, 4'b0100, 1'b1, 1'b0, 1'b0, 3};
        vecs[8] = '{4'b1100, 4'b1010, 1'b1, 1'b0, 1'b0, 2};

        // Reset with START asserted: reset must win.
        RSTN  = 1'b0;
        START = 1'b1;
        A     = 4'b1010;
        B     = 4'b0101;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 32'({BUSY, DONE, AGTB, ALTB, AEQB}), 32'd0);
        RSTN  = 1'b1;
        START = 1'b0;
        @(posedge CLK); #1;
        chk("idle_after_reset", 32'({BUSY, DONE, AGTB, ALTB, AEQB}), 32'd0);

        for (int i = 0; i < 9; i++)
            do_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].gt, vecs[i].lt, vecs[i].eq, build_lat(vecs[i].lat_ee),
                   1'b0, 1'b0, '0, '0, 1'b0);

        // START re-pulsed while busy with different operands is ignored.
        do_cmp("repulse_lt", 4'b0101, 4'b0111, 1'b0, 1'b1, 1'b0, build_lat(3),
               1'b0, 1'b0, '0, '0, 1'b1);
        do_cmp("repulse_gt", 4'b1010, 4'b0110, 1'b1, 1'b0, 1'b0, build_lat(1),
               1'b0, 1'b0, '0, '0, 1'b1);

        // Back-to-back: START held through the DONE cycle with new operands.
        do_cmp("chain_first", 4'b1010, 4'b0110, 1'b1, 1'b0, 1'b0, build_lat(1),
               1'b0, 1'b1, 4'b0101, 4'b0111, 1'b0);
        do_cmp("chain_second", 4'b0101, 4'b0111, 1'b0, 1'b1, 1'b0, build_lat(3),
               1'b1, 1'b0, '0, '0, 1'b0);

        // Reset for one cycle during SCAN aborts without a DONE pulse.
        START = 1'b1;
        A     = 4'b1001;
        B     = 4'b1001;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        chk("midscan_busy", 32'(BUSY), 32'd1);
        RSTN = 1'b0;
        @(posedge CLK); #1;
        chk("midscan_reset_outputs", 32'({BUSY, DONE, AGTB, ALTB, AEQB}), 32'd0);
        RSTN = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge CLK); #1;
            chk("aborted_no_done", 32'({BUSY, DONE}), 32'd0);
        end
        do_cmp("after_abort", 4'b0011, 4'b1000, 1'b0, 1'b1, 1'b0, build_lat(1),
               1'b0, 1'b0, '0, '0, 1'b0);

        // Random operands against the reference model, some forced equal.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra;
            model(ra, rb, gt, lt, eq, lat);
            do_cmp($sformatf("rand%0d", i), ra, rb, gt, lt, eq, lat,
                   1'b0, 1'b0, '0, '0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
